signed_add_sat_pipe: RTL and testbench
======================================

SIGNED_ADD_SAT_PIPE -- requirements
Module: signed_add_sat_pipe

Interface
REQ-001 The block SHALL have parameter W, default 4: operand and result width in two's complement.
REQ-002 The block SHALL have parameter CNT_W, default 8: overflow event counter width.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 The block SHALL have port clk, input, 1 bit: the only clock; all state on rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port up_valid, input, 1 bit: upstream operand pair valid.
REQ-007 The block SHALL have port up_ready, output, 1 bit: block accepts the operand pair this cycle.
REQ-008 The block SHALL have ports a and b, input, W bits each: signed operands.
REQ-009 The block SHALL have port down_valid, output, 1 bit: result valid.
REQ-010 The block SHALL have port down_ready, input, 1 bit: downstream accepts the result.
REQ-011 The block SHALL have port sum, output, W bits: wrapped sum, a+b mod 2^W.
REQ-012 The block SHALL have port overflow, output, 1 bit: the signed sum does not fit in W bits.
REQ-013 The block SHALL have port sat_sum, output, W bits: sum clamped to [-2^(W-1), 2^(W-1)-1].
REQ-014 The block SHALL have port ovf_clr, input, 1 bit: synchronous clear of ovf_count.
REQ-015 The block SHALL have port ovf_count, output, CNT_W bits: accepted overflowed results, saturating.

Function
REQ-016 An input transfer SHALL occur on the clock edge when up_valid and up_ready are both 1.
REQ-017 An output transfer SHALL occur on the clock edge when down_valid and down_ready are both 1.
REQ-018 The pipeline SHALL have two register stages.
- S1 registers a, b, the wrapped sum and overflow.
- S2 registers sum, overflow and sat_sum.
REQ-019 Latency SHALL be 2 cycles from input transfer to down_valid when there is no stall; throughput SHALL be 1 pair per cycle.
REQ-020 overflow SHALL be 1 exactly when a[W-1]==b[W-1] and sum[W-1]!=a[W-1].
REQ-021 sat_sum SHALL follow the overflow flag:
- equals sum when overflow=0;
- equals 2^(W-1)-1 when overflow=1 and a is non-negative;
- equals -2^(W-1) when overflow=1 and a is negative.
REQ-022 Each stage SHALL advance when its successor is empty or is advancing.
- up_ready = !s1_valid || s2_advance.
- s2_advance = !s2_valid || down_ready.
REQ-023 While a stage is stalled, its data and valid SHALL hold unchanged; there SHALL be no loss, duplication or reordering.
REQ-024 up_ready SHALL NOT depend combinationally on up_valid.
REQ-025 The ovf_count update SHALL follow these rules:
- increments by 1 on each output transfer with overflow=1;
- holds at 2^CNT_W-1 and never wraps;
- if ovf_clr coincides with an increment, ovf_clr wins and the result is 0.
REQ-026 sum, overflow and sat_sum SHALL be don't-care when down_valid=0, but SHALL be stable while down_valid=1 and down_ready=0.

Reset
REQ-027 While rst_n=0, the block SHALL force immediately:
- s1_valid and down_valid to 0;
- ovf_count to 0;
- sum, overflow and sat_sum to 0.
REQ-028 A reset applied mid-operation SHALL discard in-flight pairs, with no output transfer for them afterwards.
REQ-029 The block SHALL assert up_ready in the first cycle after rst_n deasserts.

Structure
REQ-030 Shared package signed_arith_pkg SHALL hold the default W and CNT_W constants.
REQ-031 Combinational sub-module signed_add_ovf_core SHALL compute sum and overflow (inputs a, b, W); S1 SHALL instantiate it.
REQ-032 All state SHALL reside in this module; there SHALL be no memories or latches.

Verification (W=4, CNT_W=8 unless stated)
REQ-033 The bench SHALL drive 7+4 with down_ready=1 and check the result 2 cycles later:
- sum=4'b1011 (-5);
- overflow=1;
- sat_sum=7;
- ovf_count becomes 1.
REQ-034 The bench SHALL drive -4+-7, then 4+-4, then -3+-5 back-to-back and check on consecutive cycles:
- (sum 5, ovf 1, sat -8);
- (0, 0, 0);
- (-8, 0, -8).
REQ-035 The bench SHALL issue 3 pairs with down_ready=0 for 4 cycles and check:
- up_ready falls after 2 accepted pairs;
- the 3rd pair is held upstream;
- after release, 3 results emerge in order with no gaps.
REQ-036 The bench SHALL set CNT_W=2, issue 5 overflowing pairs, and check ovf_count=3; ovf_clr asserted with a 6th overflow transfer SHALL give 0.
REQ-037 The bench SHALL assert rst_n=0 asynchronously with 2 pairs in flight and check that down_valid and ovf_count drop at once and no stale result appears after release.
REQ-038 The bench SHALL compare an exhaustive 256-pair random-stall sweep against a reference model computing sum, overflow and sat_sum.

Source files
------------

// File: rtl/signed_arith_pkg.sv
// Shared constants for the signed add/saturate pipeline.
// Default operand width and overflow counter width.
package signed_arith_pkg;

   localparam int W_DEF     = 4;
   localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/signed_add_sat_pipe_if.sv
// Operand/result handshake bundle for signed_add_sat_pipe.
// master drives operands and down_ready; slave is the pipeline.
interface signed_add_sat_pipe_if
   import signed_arith_pkg::*;
#(
   parameter int W = W_DEF
);

   logic         up_valid;
   logic         up_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         down_valid;
   logic         down_ready;
   logic [W-1:0] sum;
   logic         overflow;
   logic [W-1:0] sat_sum;

   modport master (
      output up_valid, a, b, down_ready,
      input  up_ready, down_valid, sum, overflow, sat_sum
   );

   modport slave (
      input  up_valid, a, b, down_ready,
      output up_ready, down_valid, sum, overflow, sat_sum
   );

endinterface

// File: rtl/signed_add_ovf_core.sv
// Combinational wrapped add with two's complement overflow flag.
// Overflow: equal operand signs, result sign differs.
module signed_add_ovf_core #(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] sum,
   output logic         overflow
);

   assign sum      = a + b;
   assign overflow = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);

endmodule

// File: rtl/signed_add_sat_pipe.sv
// Two-stage signed adder with saturation and overflow counter.
// S1 holds operands + raw sum, S2 holds the published result.
module signed_add_sat_pipe
   import signed_arith_pkg::*;
#(
   parameter int W     = W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   signed_add_sat_pipe_if.slave io,
   input  logic                 ovf_clr,
   output logic [CNT_W-1:0]     ovf_count
);

   localparam logic [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};

   logic         s1_valid;
   logic [W-1:0] s1_a;
   logic [W-1:0] s1_b;
   logic [W-1:0] s1_sum;
   logic         s1_ovf;
   logic         s2_valid;
   logic         s2_adv;
   logic [W-1:0] core_sum;
   logic         core_ovf;
   logic         s1_neg;
   logic signed [W:0] wide;

   signed_add_ovf_core #(.W(W)) u_core (
      .a        (io.a),
      .b        (io.b),
      .sum      (core_sum),
      .overflow (core_ovf)
   );

   // Stall only when the next stage is full and not draining.
   assign s2_adv        = !s2_valid || io.down_ready;
   assign io.up_ready   = !s1_valid || s2_adv;
   assign io.down_valid = s2_valid;

   // Full-precision sign picks the clamp direction.
   assign wide   = $signed({s1_a[W-1], s1_a}) + $signed({s1_b[W-1], s1_b});
   assign s1_neg = wide < $signed({(W+1){1'b0}});

   // S1: capture operands and the core's wrapped sum/overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_sum   <= '0;
         s1_ovf   <= 1'b0;
      end else if (io.up_ready) begin
         s1_valid <= io.up_valid;
         if (io.up_valid) begin
            s1_a   <= io.a;
            s1_b   <= io.b;
            s1_sum <= core_sum;
            s1_ovf <= core_ovf;
         end
      end
   end

   // S2: publish result; held while downstream stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid    <= 1'b0;
         io.sum      <= '0;
         io.overflow <= 1'b0;
         io.sat_sum  <= '0;
      end else if (s2_adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            io.sum      <= s1_sum;
            io.overflow <= s1_ovf;
            io.sat_sum  <= s1_ovf ? (s1_neg ? MIN_V : MAX_V) : s1_sum;
         end
      end
   end

   // Count overflowed output transfers; clear wins, no wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_count <= '0;
      end else if (ovf_clr) begin
         ovf_count <= '0;
      end else if (s2_valid && io.down_ready && io.overflow
                   && (ovf_count != '1)) begin
         ovf_count <= ovf_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_signed_add_sat_pipe.sv
// Bench for signed_add_sat_pipe: directed cases plus a
// randomized-stall sweep over all operand pairs.
module tb_signed_add_sat_pipe;

   localparam int W = 4;

   typedef struct {
      logic [3:0] sum;
      logic       ovf;
      logic [3:0] sat;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ovf_clr = 1'b0;
   logic [7:0] cnt8;
   logic [1:0] cnt2;

   exp_t q[$];
   int   total = 0;
   int   bad = 0;
   int   xfers = 0;
   int   m8 = 0;
   int   m2 = 0;
   int   n0;
   bit   last_acc;
   bit   hold = 0;
   logic [3:0] hold_sum;
   logic [3:0] hold_sat;
   logic       hold_ovf;

   signed_add_sat_pipe_if #(.W(W)) io8 ();
   signed_add_sat_pipe_if #(.W(W)) io2 ();

   assign io2.up_valid   = io8.up_valid;
   assign io2.a          = io8.a;
   assign io2.b          = io8.b;
   assign io2.down_ready = io8.down_ready;

   signed_add_sat_pipe #(.W(W), .CNT_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .io        (io8),
      .ovf_clr   (ovf_clr),
      .ovf_count (cnt8)
   );

   signed_add_sat_pipe #(.W(W), .CNT_W(2)) dut2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .io        (io2),
      .ovf_clr   (ovf_clr),
      .ovf_count (cnt2)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input int x, input int y);
      exp_t e;
      int   s;
      s     = x + y;
      e.ovf = (s > 7) || (s < -8);
      e.sum = 4'(s);
      if (s > 7)       e.sat = 4'd7;
      else if (s < -8) e.sat = 4'b1000;
      else             e.sat = 4'(s);
      return e;
   endfunction

   task automatic step(input bit v, input int x, input int y,
                       input bit dr, input bit clr);
      exp_t e;
      @(negedge clk);
      io8.down_ready = dr;
      ovf_clr        = clr;
      io8.up_valid   = v;
      io8.a          = 4'(x);
      io8.b          = 4'(y);
      #1;
      if (hold) begin
         chk("hold_dv", io8.down_valid, 1);
         chk("hold_sum", io8.sum, hold_sum);
         chk("hold_ovf", io8.overflow, hold_ovf);
         chk("hold_sat", io8.sat_sum, hold_sat);
      end
      hold     = io8.down_valid && !dr;
      hold_sum = io8.sum;
      hold_ovf = io8.overflow;
      hold_sat = io8.sat_sum;
      if (io8.down_valid && dr) begin
         xfers++;
         chk("q_nonempty", q.size() > 0, 1);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("sum", io8.sum, e.sum);
            chk("ovf", io8.overflow, e.ovf);
            chk("sat", io8.sat_sum, e.sat);
            if (e.ovf) begin
               if (m8 < 255) m8++;
               if (m2 < 3) m2++;
            end
         end
      end
      if (clr) begin
         m8 = 0;
         m2 = 0;
      end
      last_acc = v && io8.up_ready;
      if (last_acc) q.push_back(model(x, y));
      @(posedge clk);
      #1;
      chk("cnt8", cnt8, m8);
      chk("cnt2", cnt2, m2);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, 0, 0, 1, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      io8.up_valid   = 1'b0;
      io8.a          = '0;
      io8.b          = '0;
      io8.down_ready = 1'b0;
      #3;
      chk("rst_dv", io8.down_valid, 0);
      chk("rst_cnt8", cnt8, 0);
      chk("rst_cnt2", cnt2, 0);
      chk("rst_sum", io8.sum, 0);
      chk("rst_ovf", io8.overflow, 0);
      chk("rst_sat", io8.sat_sum, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("ur_after_rst", io8.up_ready, 1);

      // 7 + 4 overflows to -5, clamps to 7
      step(1, 7, 4, 1, 0);
      chk("lat_dv0", io8.down_valid, 0);
      step(0, 0, 0, 1, 0);
      chk("lat_dv1", io8.down_valid, 1);
      chk("d1_sum", io8.sum, 4'b1011);
      chk("d1_ovf", io8.overflow, 1);
      chk("d1_sat", io8.sat_sum, 7);
      step(0, 0, 0, 1, 0);
      chk("d1_cnt", cnt8, 1);

      // back-to-back trio
      step(1, -4, -7, 1, 0);
      step(1, 4, -4, 1, 0);
      chk("b1_dv", io8.down_valid, 1);
      chk("b1_sum", io8.sum, 5);
      chk("b1_ovf", io8.overflow, 1);
      chk("b1_sat", io8.sat_sum, 4'b1000);
      step(1, -3, -5, 1, 0);
      chk("b2_dv", io8.down_valid, 1);
      chk("b2_sum", io8.sum, 0);
      chk("b2_ovf", io8.overflow, 0);
      chk("b2_sat", io8.sat_sum, 0);
      step(0, 0, 0, 1, 0);
      chk("b3_dv", io8.down_valid, 1);
      chk("b3_sum", io8.sum, 4'b1000);
      chk("b3_ovf", io8.overflow, 0);
      chk("b3_sat", io8.sat_sum, 4'b1000);
      idle(2);

      // stall: down_ready low for 4 cycles, 3 pairs offered
      step(1, 1, 1, 0, 0);
      chk("st_ur1", io8.up_ready, 1);
      step(1, 2, 2, 0, 0);
      chk("st_ur0", io8.up_ready, 0);
      step(1, 3, 3, 0, 0);
      chk("st_held_ur", io8.up_ready, 0);
      chk("st_held_q", q.size(), 2);
      step(1, 3, 3, 0, 0);
      chk("st_dv", io8.down_valid, 1);
      chk("st_sum", io8.sum, 2);
      n0 = xfers;
      step(1, 3, 3, 1, 0);
      idle(2);
      chk("st_burst", xfers - n0, 3);
      chk("st_empty", q.size(), 0);

      // small counter saturates, clear beats increment
      for (int k = 0; k < 5; k++) step(1, 7, 7, 1, 0);
      idle(3);
      chk("cnt2_sat", cnt2, 3);
      step(1, 7, 7, 1, 0);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 1);
      chk("clr_win8", cnt8, 0);
      chk("clr_win2", cnt2, 0);

      // async reset with pairs in flight
      step(1, 7, 7, 1, 0);
      step(1, 6, 6, 1, 0);
      step(1, -8, -8, 1, 0);
      #2;
      chk("pre_rst_cnt", cnt8, 1);
      chk("pre_rst_dv", io8.down_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_dv", io8.down_valid, 0);
      chk("mid_rst_cnt8", cnt8, 0);
      chk("mid_rst_cnt2", cnt2, 0);
      q.delete();
      m8 = 0;
      m2 = 0;
      hold = 0;
      io8.up_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("mid_ur", io8.up_ready, 1);
      n0 = xfers;
      idle(4);
      chk("no_stale", xfers - n0, 0);

      // all 256 pairs, random gaps and stalls
      for (int i = 0; i < 256; i++) begin
         logic [3:0] hi;
         logic [3:0] lo;
         int         tries;
         hi = i[7:4];
         lo = i[3:0];
         tries = 0;
         last_acc = 0;
         while (!last_acc && tries < 64) begin
            step($urandom_range(0, 3) != 0, int'($signed(hi)),
                 int'($signed(lo)), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 15) == 0);
            tries++;
         end
         chk("sweep_acc", last_acc, 1);
      end
      for (int k = 0; k < 100 && q.size() > 0; k++) idle(1);
      chk("drain", q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
